// File: rtl/log2_pipe_pkg.sv
// Shared types and helpers for the pipelined floor/ceil log2 unit.
// The LOG2_PIPE_CEIL_EN macro enables ceil rounding in final_log().
package log2_pkg;

    // Payload fields are sized for the widest supported operand (128 bits).
    // Narrower builds leave the upper bits at zero, and synthesis removes them.
    localparam int MAX_LOG_W = 7;
    localparam int MAX_PAD   = 1 << MAX_LOG_W;

    typedef struct packed {
        logic                 valid;
        logic [MAX_LOG_W-1:0] res;
        logic [MAX_PAD-1:0]   win;
        logic                 zero;
        logic                 npow2;
        logic                 ceil;
    } stage_t;

    function automatic int pad_width(input int width);
        return 1 << $clog2(width);
    endfunction

    function automatic logic [MAX_LOG_W:0] final_log(input stage_t p);
        logic [MAX_LOG_W:0] r;
        r = {1'b0, p.res};
`ifdef LOG2_PIPE_CEIL_EN
        if (p.ceil && p.npow2 && !p.zero) begin
            r = r + (MAX_LOG_W+1)'(1);
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/log2_pipe_if.sv
// Operand/result handshake bundle for log2_pipe.
// The ceil_mode signal exists only when LOG2_PIPE_CEIL_EN is defined.
interface log2_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int LOG_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
`ifdef LOG2_PIPE_CEIL_EN
    logic             ceil_mode;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [LOG_W:0]   out_log;
    logic             out_zero;
    logic             busy;

`ifdef LOG2_PIPE_CEIL_EN
    modport master (
        output in_valid, in_data, ceil_mode, out_ready,
        input  in_ready, out_valid, out_log, out_zero, busy
    );
    modport slave (
        input  in_valid, in_data, ceil_mode, out_ready,
        output in_ready, out_valid, out_log, out_zero, busy
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_log, out_zero, busy
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_log, out_zero, busy
    );
`endif

endinterface

// File: rtl/log2_pipe_stage.sv
// One binary-search stage.  Stage K halves a window of 2^(LOG_W-K) bits
// and resolves result bit LOG_W-1-K.  It holds its payload while downstream stalls.
module log2_stage
    import log2_pkg::*;
#(
    parameter int LOG_W = 3,
    parameter int K     = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  stage_t in_pl,
    input  logic   dn_ready,
    output logic   up_ready,
    output stage_t out_pl
);
    localparam int HALF = 1 << (LOG_W - K - 1);
    localparam int BIT  = LOG_W - 1 - K;
    localparam logic [MAX_PAD-1:0] LO_MASK = (MAX_PAD'(1) << HALF) - MAX_PAD'(1);

    logic   upper;
    stage_t nxt;

    assign up_ready = !out_pl.valid || dn_ready;

    // Bits above the current window are always zero, so a plain shift isolates the upper half.
    always_comb begin
        nxt     = in_pl;
        upper   = (in_pl.win >> HALF) != '0;
        nxt.win = upper ? (in_pl.win >> HALF) : (in_pl.win & LO_MASK);
        nxt.res = in_pl.res | (MAX_LOG_W'(upper) << BIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pl <= '0;
        end else if (up_ready) begin
            out_pl <= nxt;
        end
    end

endmodule

// File: rtl/log2_pipe.sv
// Pipelined leading-one (floor log2) unit with valid/ready handshakes on both sides.
// When LOG2_PIPE_CEIL_EN is defined, a per-operand ceil_mode selects ceil rounding.
module log2_pipe
    import log2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG_W = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    log2_pipe_if.slave bus
);
    localparam int PAD = pad_width(WIDTH);

    stage_t             entry;
    stage_t             pl_q [LOG_W];
    logic [LOG_W:0]     rdy;
    logic [MAX_LOG_W:0] log_full;
    logic               busy_c;

    // The operand is zero-extended to the padded power-of-two width on entry.
    always_comb begin
        entry       = '0;
        entry.valid = bus.in_valid;
        entry.win   = MAX_PAD'(PAD'(bus.in_data));
        entry.zero  = bus.in_data == '0;
`ifdef LOG2_PIPE_CEIL_EN
        entry.npow2 = (bus.in_data & (bus.in_data - WIDTH'(1))) != '0;
        entry.ceil  = bus.ceil_mode;
`endif
    end

    assign rdy[LOG_W] = bus.out_ready;
    assign bus.in_ready = rdy[0];

    for (genvar k = 0; k < LOG_W; k++) begin : g_stage
        stage_t stage_in;
        if (k == 0) begin : g_first
            assign stage_in = entry;
        end else begin : g_rest
            assign stage_in = pl_q[k-1];
        end
        log2_stage #(
            .LOG_W (LOG_W),
            .K     (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_pl    (stage_in),
            .dn_ready (rdy[k+1]),
            .up_ready (rdy[k]),
            .out_pl   (pl_q[k])
        );
    end

    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < LOG_W; k++) begin
            busy_c = busy_c | pl_q[k].valid;
        end
    end

    assign log_full      = final_log(pl_q[LOG_W-1]);
    assign bus.out_log   = (LOG_W+1)'(log_full);
    assign bus.out_zero  = pl_q[LOG_W-1].zero;
    assign bus.out_valid = pl_q[LOG_W-1].valid;
    assign bus.busy      = busy_c;

endmodule

// File: tb/tb_log2_pipe.sv
// Directed self-checking bench for log2_pipe (WIDTH=8 and WIDTH=12 instances).
// The ceil scenario is compiled in only when LOG2_PIPE_CEIL_EN is defined.
module tb_log2_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    log2_pipe_if #(.WIDTH(8))  if8 ();
    log2_pipe_if #(.WIDTH(12)) if12 ();

    log2_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    log2_pipe #(.WIDTH(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(if12.slave));

    localparam logic [7:0] B2B_OPS [4] = '{8'h01, 8'h80, 8'h00, 8'hFF};
    localparam logic [3:0] B2B_LOG [4] = '{4'd0, 4'd7, 4'd0, 4'd7};
    localparam logic       B2B_Z   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    localparam logic [7:0] BP_OPS [5] = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h00};
    localparam logic [3:0] BP_LOG [5] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd0};

    localparam logic [11:0] W12_OPS [3] = '{12'h800, 12'h7FF, 12'h001};
    localparam logic [4:0]  W12_LOG [3] = '{5'd11, 5'd10, 5'd0};

`ifdef LOG2_PIPE_CEIL_EN
    localparam logic [7:0] CL_OPS  [6] = '{8'h80, 8'h81, 8'h03, 8'h81, 8'h03, 8'h00};
    localparam logic       CL_MODE [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [3:0] CL_LOG  [6] = '{4'd7, 4'd8, 4'd2, 4'd7, 4'd1, 4'd0};
    localparam logic       CL_Z    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

    task automatic test_reset();
        rst_n = 1'b0;
        if8.in_valid = 1'b0;  if8.in_data = '0;  if8.out_ready = 1'b0;
        if12.in_valid = 1'b0; if12.in_data = '0; if12.out_ready = 1'b0;
`ifdef LOG2_PIPE_CEIL_EN
        if8.ceil_mode = 1'b0; if12.ceil_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (if8.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %0b expected 1", if8.in_ready); end
        n_cmp++; if (if8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b expected 0", if8.out_valid); end
        n_cmp++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b expected 0", if8.busy); end
        n_cmp++; if (if8.out_log !== 4'd0) begin n_bad++; $display("FAIL rst_out_log: got %0d expected 0", if8.out_log); end
        n_cmp++; if (if8.out_zero !== 1'b0) begin n_bad++; $display("FAIL rst_out_zero: got %0b expected 0", if8.out_zero); end
        n_cmp++; if (if12.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_w12_in_ready: got %0b expected 1", if12.in_ready); end
    endtask

    task automatic test_single();
        int lat;
        if8.out_ready = 1'b1;
        if8.in_valid  = 1'b1;
        if8.in_data   = 8'h5A;
        @(negedge clk);
        if8.in_valid = 1'b0;
        lat = 1;
        while (if8.out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL single_latency: got %0d expected 3", lat); end
        n_cmp++; if (if8.out_log !== 4'd6) begin n_bad++; $display("FAIL single_log: got %0d expected 6", if8.out_log); end
        n_cmp++; if (if8.out_zero !== 1'b0) begin n_bad++; $display("FAIL single_zero: got %0b expected 0", if8.out_zero); end
        @(negedge clk);
        n_cmp++; if (if8.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drained: got %0b expected 0", if8.out_valid); end
    endtask

    task automatic test_back_to_back();
        if8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                n_cmp++; if (if8.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got %0b expected 1", i, if8.in_ready); end
                if8.in_valid = 1'b1;
                if8.in_data  = B2B_OPS[i];
            end else begin
                if8.in_valid = 1'b0;
            end
            if (i >= 3 && i < 7) begin
                n_cmp++; if (if8.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", i-3, if8.out_valid); end
                n_cmp++; if (if8.out_log !== B2B_LOG[i-3]) begin n_bad++; $display("FAIL b2b_log[%0d]: got %0d expected %0d", i-3, if8.out_log, B2B_LOG[i-3]); end
                n_cmp++; if (if8.out_zero !== B2B_Z[i-3]) begin n_bad++; $display("FAIL b2b_zero[%0d]: got %0b expected %0b", i-3, if8.out_zero, B2B_Z[i-3]); end
            end
            @(negedge clk);
        end
        n_cmp++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy: got %0b expected 0", if8.busy); end
    endtask

    task automatic test_backpressure();
        int idx;
        int got;
        int cyc;
        if8.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if8.in_valid = 1'b1;
            if8.in_data  = BP_OPS[idx];
            if (if8.in_ready === 1'b1 && idx < 4) idx++;
            @(negedge clk);
        end
        n_cmp++; if (idx != 3) begin n_bad++; $display("FAIL bp_accepted: got %0d expected 3", idx); end
        n_cmp++; if (if8.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_full: got %0b expected 0", if8.in_ready); end
        n_cmp++; if (if8.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %0b expected 1", if8.out_valid); end
        n_cmp++; if (if8.out_log !== BP_LOG[0]) begin n_bad++; $display("FAIL bp_stall_log: got %0d expected %0d", if8.out_log, BP_LOG[0]); end
        @(negedge clk);
        n_cmp++; if (if8.out_log !== BP_LOG[0]) begin n_bad++; $display("FAIL bp_stall_hold: got %0d expected %0d", if8.out_log, BP_LOG[0]); end
        n_cmp++; if (if8.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_hold: got %0b expected 0", if8.in_ready); end

        if8.out_ready = 1'b1;
        #1;
        got = 0;
        cyc = 0;
        while ((got < 5 || idx < 5) && cyc < 30) begin
            if (if8.out_valid === 1'b1) begin
                if (got < 5) begin
                    n_cmp++; if (if8.out_log !== BP_LOG[got]) begin n_bad++; $display("FAIL bp_drain_log[%0d]: got %0d expected %0d", got, if8.out_log, BP_LOG[got]); end
                end
                got++;
            end
            if (idx < 5) begin
                if8.in_valid = 1'b1;
                if8.in_data  = BP_OPS[idx];
                if (if8.in_ready === 1'b1) idx++;
            end else begin
                if8.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if8.in_valid = 1'b0;
        n_cmp++; if (got != 5) begin n_bad++; $display("FAIL bp_drain_count: got %0d expected 5", got); end
        n_cmp++; if (idx != 5) begin n_bad++; $display("FAIL bp_accept_total: got %0d expected 5", idx); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_w12();
        int lat;
        if12.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if12.in_valid = 1'b1;
            if12.in_data  = W12_OPS[i];
            @(negedge clk);
            if12.in_valid = 1'b0;
            lat = 1;
            while (if12.out_valid !== 1'b1 && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL w12_latency[%0d]: got %0d expected 4", i, lat); end
            n_cmp++; if (if12.out_log !== W12_LOG[i]) begin n_bad++; $display("FAIL w12_log[%0d]: got %0d expected %0d", i, if12.out_log, W12_LOG[i]); end
            n_cmp++; if (if12.out_zero !== 1'b0) begin n_bad++; $display("FAIL w12_zero[%0d]: got %0b expected 0", i, if12.out_zero); end
            @(negedge clk);
        end
    endtask

`ifdef LOG2_PIPE_CEIL_EN
    task automatic test_ceil();
        if8.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                if8.in_valid  = 1'b1;
                if8.in_data   = CL_OPS[i];
                if8.ceil_mode = CL_MODE[i];
            end else begin
                if8.in_valid  = 1'b0;
                if8.ceil_mode = 1'b0;
            end
            if (i >= 3 && i < 9) begin
                n_cmp++; if (if8.out_valid !== 1'b1) begin n_bad++; $display("FAIL ceil_valid[%0d]: got %0b expected 1", i-3, if8.out_valid); end
                n_cmp++; if (if8.out_log !== CL_LOG[i-3]) begin n_bad++; $display("FAIL ceil_log[%0d]: got %0d expected %0d", i-3, if8.out_log, CL_LOG[i-3]); end
                n_cmp++; if (if8.out_zero !== CL_Z[i-3]) begin n_bad++; $display("FAIL ceil_zero[%0d]: got %0b expected %0b", i-3, if8.out_zero, CL_Z[i-3]); end
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_reset_midflight();
        int stale;
        int lat;
        if8.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if8.in_valid = 1'b1;
            if8.in_data  = 8'h20 << i;
            @(negedge clk);
        end
        if8.in_valid = 1'b0;
        n_cmp++; if (if8.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %0b expected 1", if8.busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (if8.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid: got %0b expected 0", if8.out_valid); end
        n_cmp++; if (if8.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %0b expected 0", if8.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        if8.out_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (if8.out_valid === 1'b1) stale++;
        end
        n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL mid_stale_results: got %0d expected 0", stale); end
        if8.in_valid = 1'b1;
        if8.in_data  = 8'h10;
        @(negedge clk);
        if8.in_valid = 1'b0;
        lat = 1;
        while (if8.out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL mid_post_latency: got %0d expected 3", lat); end
        n_cmp++; if (if8.out_log !== 4'd4) begin n_bad++; $display("FAIL mid_post_log: got %0d expected 4", if8.out_log); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_w12();
`ifdef LOG2_PIPE_CEIL_EN
        test_ceil();
`endif
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/log2_pipe.md
# log2_pipe

Parametrised, pipelined floor-log2 (leading-one position) unit with valid/ready handshakes on both sides.
- Accepts one WIDTH-bit unsigned operand per cycle.
- Resolves one result bit per pipeline stage by binary search.
- Returns the index of the most significant set bit, plus a zero flag.
- Sits between datapath producers (normalisers, range estimators) and consumers that need a magnitude exponent, replacing single-cycle combinational priority encoders where WIDTH makes them timing-critical.

## Interface
Parameters:
- WIDTH, 8: operand width; any value ≥ 2. Not required to be a power of two.
- LOG_W, $clog2(WIDTH): derived. Equals the number of pipeline stages and the floor-result width. Not to be overridden.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand present
- in_ready  out  1  unit can accept operand this cycle
- in_data  in  WIDTH  unsigned operand
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- out_log  out  LOG_W+1  log2 result; MSB is 0 unless ceil mode produces 2^LOG_W
- out_zero  out  1  operand was zero
- busy  out  1  OR of all stage valid bits

## Operation
- The operand is zero-extended to 2^LOG_W bits on entry.
- Stage k (k = 0..LOG_W-1) holds a window of 2^(LOG_W-k) bits and resolves result bit LOG_W-1-k:
  - If the upper half of the window is nonzero: the bit is 1 and the upper half is kept.
  - Otherwise: the bit is 0 and the lower half is kept.
- Each stage carries its valid bit, the partial result, the window, the zero flag (in_data == 0, captured at entry) and the non-power-of-two flag (see Configuration).
- Zero operand: out_log = 0 and out_zero = 1. All other operands give out_zero = 0.
- Floor result: for in_data ≠ 0, out_log = index of the highest set bit of in_data.
- Backpressure:
  - Per-stage ready[k] = !valid[k] || ready[k+1], with ready[LOG_W] = out_ready.
  - in_ready = ready[0].
  - A stage loads only when its own ready is high, and holds its contents otherwise.
- in_ready never depends combinationally on in_valid. out_valid never depends on out_ready.
- Transfer rules:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - Simultaneous input and output transfers in the same cycle are permitted and required for full throughput.
- Results leave in the same order operands entered. No reordering, no dropping.

## Timing
- Latency: LOG_W cycles from input transfer to out_valid, with no backpressure (WIDTH=8: 3 cycles).
- Throughput: one operand per cycle while out_ready is held high.
- Capacity: LOG_W operands in flight. With out_ready low and the pipeline full, in_ready = 0.
- Stall: while out_valid && !out_ready, out_log and out_zero stay stable.
- Reset (asynchronous assert, release synchronised externally):
  - All stage valids clear; out_valid = 0, busy = 0.
  - out_log = 0, out_zero = 0.
  - in_ready = 1 from the first cycle after release.
- Reset mid-operation discards all in-flight operands. No partial result is emitted.

## Configuration
- LOG2_PIPE_CEIL_EN defined:
  - Adds input port ceil_mode (1 bit), sampled with in_data and carried through the pipeline.
  - When the sampled ceil_mode = 1: out_log = floor + 1 if in_data is not a power of two; for powers of two it equals floor.
  - The not-power-of-two flag is computed at entry as (in_data & (in_data-1)) ≠ 0.
  - Zero operand gives out_log = 0, out_zero = 1.
- LOG2_PIPE_CEIL_EN undefined: no ceil_mode port, no flag registers, out_log MSB tied to 0.

## Structure
- Package log2_pkg:
  - Stage payload struct (valid, partial result, window, zero flag, non-power-of-two flag, ceil flag).
  - Function computing the padded width 2^LOG_W.
- Sub-module log2_stage: one binary-search stage with its local ready logic, instantiated LOG_W times by a generate loop. The top level contains only the entry zero-extension, the generate loop and the output mapping.

## Test plan
- WIDTH=8, single operand 0x5A, out_ready=1 -> out_valid after 3 cycles, out_log=6, out_zero=0.
- WIDTH=8, back-to-back 0x01, 0x80, 0x00, 0xFF -> out_log 0, 7, 0 (out_zero=1), 7 on consecutive cycles; in_ready stays 1.
- WIDTH=8, out_ready=0 while 5 operands are offered -> exactly 3 accepted, then in_ready=0; out_log held stable. Releasing out_ready drains the results in order, then the remaining 2 operands are accepted.
- WIDTH=12, operands 0x800 and 0x7FF -> out_log 11 and 10, 4-cycle latency (padding to 16 bits handled).
- LOG2_PIPE_CEIL_EN, WIDTH=8, ceil_mode=1:
  - 0x80 -> 7; 0x81 -> 8 (out_log=4'b1000); 0x03 -> 2.
  - Mixed per-operand ceil_mode is honoured.
- rst_n asserted with 3 operands in flight -> out_valid=0 and busy=0 immediately. After release, no stale result appears and the next operand 0x10 returns 4.
